// File: rtl/reduce_gate_sweeper_pkg.sv
// Shared types for reduce_gate_sweeper: FSM state encoding, sweep function
// select codes and the helper that picks the selected reduction.
package reduce_gate_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_OR  = 2'd0,
      SEL_AND = 2'd1,
      SEL_XOR = 2'd2,
      SEL_NOR = 2'd3
   } sel_t;

   function automatic logic pick_fn(input sel_t s, input logic f_or, input logic f_and,
                                    input logic f_xor, input logic f_nor);
      logic r;
      case (s)
         SEL_OR:  r = f_or;
         SEL_AND: r = f_and;
         SEL_XOR: r = f_xor;
         default: r = f_nor;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/reduce_gate_sweeper_core.sv
// Combinational N-input OR/AND/XOR/NOR reduction.
// XOR is only built when REDUCE_XOR_EN is defined; otherwise xor_o is tied low.
module reduce_gate_core
   import reduce_gate_sweeper_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   output logic         or_o,
   output logic         and_o,
   output logic         xor_o,
   output logic         nor_o
);

   assign or_o  = |a_i;
   assign and_o = &a_i;
   assign nor_o = ~|a_i;

`ifdef REDUCE_XOR_EN
   assign xor_o = ^a_i;
`else
   assign xor_o = 1'b0;
`endif

endmodule

// File: rtl/reduce_gate_sweeper.sv
// N-input reduction gate with registered outputs and an exhaustive pattern sweeper
// that counts patterns where the selected function is 1. Macro: REDUCE_XOR_EN.
module reduce_gate_sweeper
   import reduce_gate_sweeper_pkg::*;
#(
   parameter int N    = 4,
   parameter int HOLD = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] ext_in,
   input  logic         start,
   input  logic [1:0]   sel,
   output logic         y_or,
   output logic         y_and,
   output logic         y_xor,
   output logic         y_nor,
   output logic [N-1:0] pattern,
   output logic         busy,
   output logic         done,
   output logic [N:0]   hit_count
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   state_t          state_q, state_d;
   logic [N-1:0]    pattern_q, pattern_d;
   logic [HW-1:0]   hold_q, hold_d;
   sel_t            sel_q, sel_d;
   logic [N:0]      hit_q, hit_d;
   logic            y_or_q, y_and_q, y_xor_q, y_nor_q;

   logic [N-1:0]    src;
   logic            r_or, r_and, r_xor, r_nor;
   logic            f_sel;

   assign src = (state_q == SWEEP) ? pattern_q : ext_in;

   reduce_gate_core #(.N(N)) u_core (
      .a_i   (src),
      .or_o  (r_or),
      .and_o (r_and),
      .xor_o (r_xor),
      .nor_o (r_nor)
   );

   // In SWEEP the core sees pattern_q, so its outputs double as the hit test.
   assign f_sel = pick_fn(sel_q, r_or, r_and, r_xor, r_nor);

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      hold_d    = hold_q;
      sel_d     = sel_q;
      hit_d     = hit_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SWEEP;
               sel_d     = sel_t'(sel);
               hit_d     = '0;
               pattern_d = '0;
               hold_d    = '0;
            end
         end
         SWEEP: begin
            if (hold_q == HOLD_LAST) begin
               if (f_sel) hit_d = hit_q + (N+1)'(1);
               hold_d = '0;
               if (pattern_q == '1) begin
                  state_d   = DONE;
                  pattern_d = '0;
               end else begin
                  pattern_d = pattern_q + N'(1);
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         hold_q    <= '0;
         sel_q     <= SEL_OR;
         hit_q     <= '0;
         y_or_q    <= 1'b0;
         y_and_q   <= 1'b0;
         y_xor_q   <= 1'b0;
         y_nor_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         hold_q    <= hold_d;
         sel_q     <= sel_d;
         hit_q     <= hit_d;
         y_or_q    <= r_or;
         y_and_q   <= r_and;
         y_xor_q   <= r_xor;
         y_nor_q   <= r_nor;
      end
   end

   assign y_or      = y_or_q;
   assign y_and     = y_and_q;
   assign y_xor     = y_xor_q;
   assign y_nor     = y_nor_q;
   assign pattern   = pattern_q;
   assign busy      = (state_q == SWEEP);
   assign done      = (state_q == DONE);
   assign hit_count = hit_q;

endmodule

// File: tb/tb_reduce_gate_sweeper.sv
// Scoreboard bench for reduce_gate_sweeper: one instance with HOLD=1, one with HOLD=3.
module tb_reduce_gate_sweeper;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start1 = 1'b0, start3 = 1'b0;
   logic [N-1:0] ext_in = '0;
   logic [1:0]   sel = 2'd0;

   logic         y_or1, y_and1, y_xor1, y_nor1, busy1, done1;
   logic [N-1:0] pat1;
   logic [N:0]   hit1;
   logic         y_or3, y_and3, y_xor3, y_nor3, busy3, done3;
   logic [N-1:0] pat3;
   logic [N:0]   hit3;

   int n_chk = 0;
   int n_err = 0;
   int hsel  = 1;

   logic [3:0] gate_q[$];
   int         hit_q[$];

   logic         m_busy, m_done, m_yor;
   logic [N-1:0] m_pat;
   logic [N:0]   m_hit;

   assign m_busy = (hsel == 1) ? busy1 : busy3;
   assign m_done = (hsel == 1) ? done1 : done3;
   assign m_yor  = (hsel == 1) ? y_or1 : y_or3;
   assign m_pat  = (hsel == 1) ? pat1  : pat3;
   assign m_hit  = (hsel == 1) ? hit1  : hit3;

   always #5 clk = ~clk;

   reduce_gate_sweeper #(.N(N), .HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .ext_in(ext_in), .start(start1), .sel(sel),
      .y_or(y_or1), .y_and(y_and1), .y_xor(y_xor1), .y_nor(y_nor1),
      .pattern(pat1), .busy(busy1), .done(done1), .hit_count(hit1)
   );

   reduce_gate_sweeper #(.N(N), .HOLD(3)) dut3 (
      .clk(clk), .rst(rst), .ext_in(ext_in), .start(start3), .sel(sel),
      .y_or(y_or3), .y_and(y_and3), .y_xor(y_xor3), .y_nor(y_nor3),
      .pattern(pat3), .busy(busy3), .done(done3), .hit_count(hit3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // {or, and, xor, nor}
   function automatic logic [3:0] gate_model(input logic [3:0] v);
      logic x;
      x = 1'b0;
`ifdef REDUCE_XOR_EN
      x = ^v;
`endif
      return {|v, &v, x, ~|v};
   endfunction

   function automatic int hit_model(input logic [1:0] s);
      int c;
      logic [3:0] v, g;
      c = 0;
      for (int p = 0; p < 16; p++) begin
         v = 4'(p);
         g = gate_model(v);
         if (g[3 - int'(s)]) c++;
      end
      return c;
   endfunction

   task automatic gate_test(input logic [3:0] v);
      logic [3:0] e;
      ext_in = v;
      gate_q.push_back(gate_model(v));
      step;
      e = gate_q.pop_front();
      check("y_or",  y_or1,  e[3]);
      check("y_and", y_and1, e[2]);
      check("y_xor", y_xor1, e[1]);
      check("y_nor", y_nor1, e[0]);
   endtask

   task automatic sweep(input int h, input logic [1:0] s, input int restart_at);
      int cyc;
      int exp_hit;
      hsel = h;
      sel  = s;
      if (h == 1) start1 = 1'b1; else start3 = 1'b1;
      hit_q.push_back(hit_model(s));
      step;
      start1 = 1'b0;
      start3 = 1'b0;
      sel    = ~s;
      cyc    = 0;
      while (m_busy && cyc < 400) begin
         check("pattern", m_pat, cyc / h);
         if (cyc >= 1) check("y_or_sweep", m_yor, ((cyc - 1) / h) != 0);
         check("done_low", m_done, 0);
         if (cyc == restart_at) begin
            if (h == 1) start1 = 1'b1; else start3 = 1'b1;
         end else begin
            start1 = 1'b0;
            start3 = 1'b0;
         end
         step;
         cyc++;
      end
      start1 = 1'b0;
      start3 = 1'b0;
      check("busy_len", cyc, 16 * h);
      check("done_pulse", m_done, 1);
      check("pattern_idle", m_pat, 0);
      exp_hit = hit_q.pop_front();
      check("hit_count", m_hit, exp_hit);
      step;
      check("done_once", m_done, 0);
      check("busy_after", m_busy, 0);
      check("hit_hold", m_hit, exp_hit);
   endtask

   initial begin
      step;
      step;
      check("rst_y1", {y_or1, y_and1, y_xor1, y_nor1}, 0);
      check("rst_y3", {y_or3, y_and3, y_xor3, y_nor3}, 0);
      check("rst_busy", {busy1, busy3, done1, done3}, 0);
      check("rst_pat", {pat1, pat3}, 0);
      check("rst_hit", {hit1, hit3}, 0);
      rst = 1'b0;
      step;

      gate_test(4'b0000);
      gate_test(4'b0100);
      gate_test(4'b1111);
      gate_test(4'b1010);
      ext_in = 4'b0000;

      sweep(1, 2'd0, 5);
      sweep(1, 2'd1, -1);
      sweep(1, 2'd2, -1);
      sweep(1, 2'd3, -1);
      sweep(3, 2'd0, -1);

      // reset mid-sweep at sweep cycle 7
      hsel = 1;
      sel = 2'd0;
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      for (int i = 0; i < 7; i++) step;
      check("pre_rst_busy", m_busy, 1);
      check("pre_rst_hit", m_hit, 6);
      rst = 1'b1;
      step;
      rst = 1'b0;
      check("rst_mid_busy", m_busy, 0);
      check("rst_mid_pat", m_pat, 0);
      check("rst_mid_hit", m_hit, 0);
      check("rst_mid_done", m_done, 0);
      step;
      check("rst_mid_nodone", m_done, 0);

      // reset and start together: reset wins
      rst = 1'b1;
      start1 = 1'b1;
      step;
      rst = 1'b0;
      start1 = 1'b0;
      check("rst_start_busy", m_busy, 0);
      step;
      check("rst_start_idle", {m_busy, m_done}, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
